// File: rtl/eth_arp_reply_tx.sv
// ARP reply generator: turns accepted ARP requests for our IP into 60-byte reply
// frames on a 64-bit AXI-Stream master, with one request queued behind the active frame.
module eth_arp_reply_tx #(
    parameter logic [47:0] FPGA_MAC = 48'h211abcdef112,
    parameter logic [31:0] FPGA_IP  = 32'hC0000186
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_arp_valid,
    input  logic [15:0] i_OPER,
    input  logic [47:0] i_SHA,
    input  logic [31:0] i_SPA,
    input  logic [31:0] i_TPA,
    output logic        o_tx_axis_tvalid,
    output logic [63:0] o_tx_axis_tdata,
    output logic        o_tx_axis_tlast,
    output logic [7:0]  o_tx_axis_tkeep,
    input  logic        i_tx_axis_tready,
    output logic        o_busy,
    output logic        o_drop
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [47:0] act_sha_reg, act_sha_next;
    logic [31:0] act_spa_reg, act_spa_next;
    logic [47:0] pend_sha_reg, pend_sha_next;
    logic [31:0] pend_spa_reg, pend_spa_next;
    logic        pend_full_reg, pend_full_next;
    logic        drop_reg, drop_next;

    logic        accept;
    logic        handshake;
    logic        last_handshake;
    logic [63:0] beat_wire;
    logic [63:0] beat_swapped;

    assign accept         = i_arp_valid && (i_OPER == 16'h0001) && (i_TPA == FPGA_IP);
    assign handshake      = (state_reg == ST_SEND) && i_tx_axis_tready;
    assign last_handshake = handshake && (cnt_reg == 3'd7);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 3'd0;
            act_sha_reg   <= 48'd0;
            act_spa_reg   <= 32'd0;
            pend_sha_reg  <= 48'd0;
            pend_spa_reg  <= 32'd0;
            pend_full_reg <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            act_sha_reg   <= act_sha_next;
            act_spa_reg   <= act_spa_next;
            pend_sha_reg  <= pend_sha_next;
            pend_spa_reg  <= pend_spa_next;
            pend_full_reg <= pend_full_next;
            drop_reg      <= drop_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        act_sha_next   = act_sha_reg;
        act_spa_next   = act_spa_reg;
        pend_sha_next  = pend_sha_reg;
        pend_spa_next  = pend_spa_reg;
        pend_full_next = pend_full_reg;
        drop_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    act_sha_next = i_SHA;
                    act_spa_next = i_SPA;
                    cnt_next     = 3'd0;
                    state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    cnt_next = cnt_reg + 3'd1;
                end
                // On the final beat the freed pending slot can absorb a same-cycle request
                if (last_handshake) begin
                    if (pend_full_reg) begin
                        act_sha_next   = pend_sha_reg;
                        act_spa_next   = pend_spa_reg;
                        pend_full_next = accept;
                        if (accept) begin
                            pend_sha_next = i_SHA;
                            pend_spa_next = i_SPA;
                        end
                    end else if (accept) begin
                        act_sha_next = i_SHA;
                        act_spa_next = i_SPA;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (accept) begin
                    if (!pend_full_reg) begin
                        pend_sha_next  = i_SHA;
                        pend_spa_next  = i_SPA;
                        pend_full_next = 1'b1;
                    end else begin
                        drop_next = 1'b1;
                    end
                end
            end
        endcase
    end

    // Beat contents in wire order: first byte of the beat in bits [63:56]
    always_comb begin
        beat_wire = 64'd0;
        case (cnt_reg)
            3'd0: beat_wire = {act_sha_reg, FPGA_MAC[47:32]};
            3'd1: beat_wire = {FPGA_MAC[31:0], 16'h0806, 16'h0001};
            3'd2: beat_wire = {16'h0800, 8'h06, 8'h04, 16'h0002, FPGA_MAC[47:32]};
            3'd3: beat_wire = {FPGA_MAC[31:0], FPGA_IP};
            3'd4: beat_wire = {act_sha_reg, act_spa_reg[31:16]};
            3'd5: beat_wire = {act_spa_reg[15:0], 48'd0};
            default: beat_wire = 64'd0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_swap
            assign beat_swapped[8*gi +: 8] = beat_wire[63-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        o_tx_axis_tvalid = 1'b0;
        o_tx_axis_tdata  = 64'd0;
        o_tx_axis_tkeep  = 8'h00;
        o_tx_axis_tlast  = 1'b0;
        if (state_reg == ST_SEND) begin
            o_tx_axis_tvalid = 1'b1;
            o_tx_axis_tdata  = beat_swapped;
            o_tx_axis_tkeep  = (cnt_reg == 3'd7) ? 8'h0F : 8'hFF;
            o_tx_axis_tlast  = (cnt_reg == 3'd7);
        end
    end

    assign o_busy = (state_reg == ST_SEND) || pend_full_reg;
    assign o_drop = drop_reg;

endmodule

// File: tb/tb_eth_arp_reply_tx.sv
// Self-checking bench for eth_arp_reply_tx: directed vector tables plus multi-cycle
// sequences for queueing, edge accept, backpressure and mid-frame reset.
module tb_eth_arp_reply_tx;

    localparam logic [47:0] MAC = 48'h211abcdef112;
    localparam logic [31:0] IP  = 32'hC0000186;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_valid = 1'b0;
    logic [15:0] oper = 16'd0;
    logic [47:0] sha = 48'd0;
    logic [31:0] spa = 32'd0;
    logic [31:0] tpa = 32'd0;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        tready = 1'b1;
    logic        busy;
    logic        drop;

    eth_arp_reply_tx #(.FPGA_MAC(MAC), .FPGA_IP(IP)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_arp_valid      (arp_valid),
        .i_OPER           (oper),
        .i_SHA            (sha),
        .i_SPA            (spa),
        .i_TPA            (tpa),
        .o_tx_axis_tvalid (tvalid),
        .o_tx_axis_tdata  (tdata),
        .o_tx_axis_tlast  (tlast),
        .o_tx_axis_tkeep  (tkeep),
        .i_tx_axis_tready (tready),
        .o_busy           (busy),
        .o_drop           (drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drop_cnt = 0;
    int stall_cnt = 0;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] tpa;
        logic        accept;
    } req_vec_t;

    beat_t    beats_q[$];
    beat_t    exp_tbl[8];
    req_vec_t filt_tbl[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference frame built byte by byte in wire order
    function automatic logic [63:0] model_beat(input logic [47:0] s, input logic [31:0] p, input int n);
        logic [7:0]  b [0:63];
        logic [63:0] r;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = s[47-8*i -: 8];
            b[6+i]    = MAC[47-8*i -: 8];
            b[22+i]   = MAC[47-8*i -: 8];
            b[32+i]   = s[47-8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
        b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
        b[20] = 8'h00; b[21] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            b[28+i] = IP[31-8*i -: 8];
            b[38+i] = p[31-8*i -: 8];
        end
        r = 64'd0;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = b[8*n+j];
        return r;
    endfunction

    // Handshake monitor: records accepted beats and checks stall stability
    logic        prev_stall = 1'b0;
    logic        in_frame = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            in_frame   = 1'b0;
        end else begin
            if (drop) drop_cnt++;
            if (prev_stall) begin
                stall_cnt++;
                check64("stall_tvalid", 64'(tvalid), 64'd1);
                check64("stall_tdata", tdata, prev_data);
                check64("stall_tkeep", 64'(tkeep), 64'(prev_keep));
                check64("stall_tlast", 64'(tlast), 64'(prev_last));
            end else if (in_frame) begin
                check64("tvalid_midframe", 64'(tvalid), 64'd1);
            end
            if (tvalid && tready) begin
                beats_q.push_back('{data: tdata, keep: tkeep, last: tlast, cyc: cyc});
                in_frame = !tlast;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_keep  = tkeep;
            prev_last  = tlast;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [15:0] op, input logic [47:0] s, input logic [31:0] p, input logic [31:0] t);
        arp_valid = 1'b1;
        oper = op;
        sha  = s;
        spa  = p;
        tpa  = t;
        tick();
        arp_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int k = 0;
        while (beats_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        check64(name, 64'(beats_q.size()), 64'(n));
    endtask

    task automatic check_frame(input int base, input logic [47:0] s, input logic [31:0] p, input string name);
        for (int n = 0; n < 8; n++) begin
            if (base + n < beats_q.size()) begin
                check64({name, "_data"}, beats_q[base+n].data, model_beat(s, p, n));
                check64({name, "_keep"}, 64'(beats_q[base+n].keep), (n == 7) ? 64'h0F : 64'hFF);
                check64({name, "_last"}, 64'(beats_q[base+n].last), (n == 7) ? 64'd1 : 64'd0);
            end else begin
                check64({name, "_missing_beat"}, 64'(beats_q.size()), 64'(base + 8));
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check64({name, "_tvalid"}, 64'(tvalid), 64'd0);
        check64({name, "_tdata"}, tdata, 64'd0);
        check64({name, "_tlast"}, 64'(tlast), 64'd0);
        check64({name, "_tkeep"}, 64'(tkeep), 64'd0);
        check64({name, "_busy"}, 64'(busy), 64'd0);
        check64({name, "_drop"}, 64'(drop), 64'd0);
    endtask

    localparam logic [47:0] SHA1 = 48'h001122334455;
    localparam logic [31:0] SPA1 = 32'hC0000101;

    initial begin
        exp_tbl[0] = '{data: 64'h1a21554433221100, keep: 8'hFF, last: 1'b0, cyc: 0};
        exp_tbl[1] = '{data: 64'h0100060812f1debc, keep: 8'hFF, last: 1'b0, cyc: 0};
        exp_tbl[2] = '{data: 64'h1a21020004060008, keep: 8'hFF, last: 1'b0, cyc: 0};
        exp_tbl[3] = '{data: 64'h860100c012f1debc, keep: 8'hFF, last: 1'b0, cyc: 0};
        exp_tbl[4] = '{data: 64'h00c0554433221100, keep: 8'hFF, last: 1'b0, cyc: 0};
        exp_tbl[5] = '{data: 64'h0000000000000101, keep: 8'hFF, last: 1'b0, cyc: 0};
        exp_tbl[6] = '{data: 64'h0000000000000000, keep: 8'hFF, last: 1'b0, cyc: 0};
        exp_tbl[7] = '{data: 64'h0000000000000000, keep: 8'h0F, last: 1'b1, cyc: 0};

        filt_tbl[0] = '{oper: 16'h0002, sha: 48'h0a0b0c0d0e0f, tpa: IP,           accept: 1'b0};
        filt_tbl[1] = '{oper: 16'h0001, sha: 48'h0a0b0c0d0e0f, tpa: 32'hC0000102, accept: 1'b0};
        filt_tbl[2] = '{oper: 16'h0101, sha: 48'h0a0b0c0d0e0f, tpa: IP,           accept: 1'b0};
        filt_tbl[3] = '{oper: 16'h0001, sha: 48'hfedcba987654, tpa: IP,           accept: 1'b1};

        // Reset state
        #3;
        check_idle_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request with tready held high, checked against the hand table
        beats_q.delete();
        check64("pre_strobe_tvalid", 64'(tvalid), 64'd0);
        strobe(16'h0001, SHA1, SPA1, IP);
        check64("latency_tvalid", 64'(tvalid), 64'd1);
        wait_beats(8, "single_beats");
        for (int i = 0; i < 8 && i < beats_q.size(); i++) begin
            check64($sformatf("single_b%0d_data", i), beats_q[i].data, exp_tbl[i].data);
            check64($sformatf("single_b%0d_keep", i), 64'(beats_q[i].keep), 64'(exp_tbl[i].keep));
            check64($sformatf("single_b%0d_last", i), 64'(beats_q[i].last), 64'(exp_tbl[i].last));
        end
        if (beats_q.size() >= 8)
            check64("single_contiguous", 64'(beats_q[7].cyc - beats_q[0].cyc), 64'd7);
        tick();
        check64("single_idle_tvalid", 64'(tvalid), 64'd0);
        check64("single_idle_busy", 64'(busy), 64'd0);

        // Accept filter
        for (int v = 0; v < 4; v++) begin
            beats_q.delete();
            drop_cnt = 0;
            strobe(filt_tbl[v].oper, filt_tbl[v].sha, SPA1, filt_tbl[v].tpa);
            check64($sformatf("filt%0d_busy", v), 64'(busy), 64'(filt_tbl[v].accept));
            repeat (12) tick();
            check64($sformatf("filt%0d_beats", v), 64'(beats_q.size()), filt_tbl[v].accept ? 64'd8 : 64'd0);
            check64($sformatf("filt%0d_drop", v), 64'(drop_cnt), 64'd0);
            if (filt_tbl[v].accept) check_frame(0, filt_tbl[v].sha, SPA1, $sformatf("filt%0d", v));
        end

        // Backpressure: tready pattern 1,0,0,1
        begin
            logic [3:0] pat;
            int k;
            pat = 4'b1001;
            beats_q.delete();
            stall_cnt = 0;
            strobe(16'h0001, SHA1, SPA1, IP);
            k = 0;
            while (beats_q.size() < 8 && k < 100) begin
                tready = pat[3 - (k % 4)];
                tick();
                k++;
            end
            tready = 1'b1;
            repeat (4) tick();
            check64("bp_beats", 64'(beats_q.size()), 64'd8);
            for (int i = 0; i < 8 && i < beats_q.size(); i++)
                check64($sformatf("bp_b%0d_data", i), beats_q[i].data, exp_tbl[i].data);
            check64("bp_stalls_seen", 64'(stall_cnt > 0), 64'd1);
        end

        // Queue: three requests in three cycles, third is dropped
        beats_q.delete();
        drop_cnt = 0;
        strobe(16'h0001, 48'h000000000001, 32'hC0000111, IP);
        strobe(16'h0001, 48'h000000000002, 32'hC0000122, IP);
        strobe(16'h0001, 48'h000000000003, 32'hC0000133, IP);
        wait_beats(16, "queue_beats");
        check_frame(0, 48'h000000000001, 32'hC0000111, "queue_f0");
        check_frame(8, 48'h000000000002, 32'hC0000122, "queue_f1");
        if (beats_q.size() >= 16)
            check64("queue_contiguous", 64'(beats_q[15].cyc - beats_q[0].cyc), 64'd15);
        repeat (10) tick();
        check64("queue_drop_count", 64'(drop_cnt), 64'd1);
        check64("queue_no_third", 64'(beats_q.size()), 64'd16);
        check64("queue_busy_end", 64'(busy), 64'd0);

        // Edge accept: second request in the beat-7 handshake cycle
        beats_q.delete();
        drop_cnt = 0;
        strobe(16'h0001, 48'h0000000000aa, 32'hC00001aa, IP);
        repeat (7) tick();
        strobe(16'h0001, 48'h0000000000bb, 32'hC00001bb, IP);
        wait_beats(16, "edge_beats");
        check_frame(0, 48'h0000000000aa, 32'hC00001aa, "edge_f0");
        check_frame(8, 48'h0000000000bb, 32'hC00001bb, "edge_f1");
        if (beats_q.size() >= 16)
            check64("edge_contiguous", 64'(beats_q[15].cyc - beats_q[0].cyc), 64'd15);
        repeat (4) tick();
        check64("edge_drop", 64'(drop_cnt), 64'd0);

        // Reset mid-frame during beat 3
        beats_q.delete();
        strobe(16'h0001, 48'h0000000000cc, 32'hC00001cc, IP);
        repeat (3) tick();
        check64("midrst_beat3", tdata, model_beat(48'h0000000000cc, 32'hC00001cc, 3));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        check64("midrst_partial", 64'(beats_q.size()), 64'd3);
        beats_q.delete();
        tick();
        strobe(16'h0001, 48'h0000000000dd, 32'hC00001dd, IP);
        wait_beats(8, "postrst_beats");
        check_frame(0, 48'h0000000000dd, 32'hC00001dd, "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
